// File: rtl/truth_table_sweeper_if.sv
//------------------------------------------------------------------------------
// truth_table_sweeper_if
//
// Purpose : bundles the control, logic-block and read-stream signals of the
//           truth-table sweeper so the harness and its environment connect
//           through a single port.
//
// Signals :
//   start          sweep request pulse (environment -> sweeper)
//   busy, done     sweep status (sweeper -> environment)
//   in1..in3       drive to the logic block under test (sweeper -> block)
//   out1..out4     logic block outputs (block -> sweeper)
//   rd_valid       row presented on rd_row/rd_data (sweeper -> consumer)
//   rd_ready       consumer accepts the presented row (consumer -> sweeper)
//   rd_row         index of the presented row
//   rd_data        captured {out1,out2,out3,out4} for rd_row
//   mismatch       any captured row differs from the expected table
//                  (only with TT_CHECK_EN)
//   mismatch_mask  per-row mismatch flags (only with TT_CHECK_EN)
//
// Modports: master = sweeper side, slave = environment / consumer side.
//------------------------------------------------------------------------------
interface truth_table_sweeper_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       out1;
    logic       out2;
    logic       out3;
    logic       out4;
    logic       rd_valid;
    logic       rd_ready;
    logic [2:0] rd_row;
    logic [3:0] rd_data;
`ifdef TT_CHECK_EN
    logic       mismatch;
    logic [7:0] mismatch_mask;
`endif

    modport master (
        input  start,
        input  out1,
        input  out2,
        input  out3,
        input  out4,
        input  rd_ready,
        output busy,
        output done,
        output in1,
        output in2,
        output in3,
        output rd_valid,
        output rd_row,
        output rd_data
`ifdef TT_CHECK_EN
        ,
        output mismatch,
        output mismatch_mask
`endif
    );

    modport slave (
        output start,
        output out1,
        output out2,
        output out3,
        output out4,
        output rd_ready,
        input  busy,
        input  done,
        input  in1,
        input  in2,
        input  in3,
        input  rd_valid,
        input  rd_row,
        input  rd_data
`ifdef TT_CHECK_EN
        ,
        input  mismatch,
        input  mismatch_mask
`endif
    );
endinterface

// File: rtl/truth_table_sweeper.sv
//------------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose : harness around a 3-input / 4-output combinational block. On a
//           start pulse it walks {in1,in2,in3} through rows 0..7, holds each
//           combination SETTLE_CYCLES cycles, captures {out1,out2,out3,out4}
//           into an 8-entry buffer and then streams the rows out over a
//           valid/ready handshake, finishing with a one-cycle done pulse.
//
// Ports   :
//   clk   sole clock, rising edge
//   rst   asynchronous active-high reset
//   tt    truth_table_sweeper_if.master (start, busy, done, in1..in3,
//         out1..out4, rd_valid, rd_ready, rd_row, rd_data
//         [, mismatch, mismatch_mask])
//
// Parameters:
//   SETTLE_CYCLES  cycles a combination is held before sampling (1..255)
//   CNT_W          settle counter width, 2**CNT_W > SETTLE_CYCLES
//   EXPECTED_TT    expected table, row r at bits [4r+3:4r]
//
// Optional feature (macro TT_CHECK_EN): compares every captured row with
// EXPECTED_TT and reports mismatch / mismatch_mask. Without the macro the
// ports and comparison logic are absent.
//------------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8,
    parameter logic [31:0] EXPECTED_TT   = 32'h6C9C6090
) (
    input logic                   clk,
    input logic                   rst,
    truth_table_sweeper_if.master tt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [2:0]       row_reg, row_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [2:0]       in_reg, in_next;
    logic [3:0]       rd_data_reg, rd_data_next;
    logic [3:0]       out_sample_reg;
    logic             buf_we;
    logic [3:0]       buf_rd [8];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next   = state_reg;
        row_next     = row_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        rd_data_next = rd_data_reg;
        buf_we       = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (tt.start) begin
                    row_next   = '0;
                    cnt_next   = '0;
                    state_next = S_APPLY;
                end
            end
            S_APPLY: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                buf_we   = 1'b1;
                cnt_next = '0;
                if (row_reg == 3'd7) begin
                    // Row 0 was captured long ago, so it can be presented
                    // on the very first STREAM cycle.
                    state_next   = S_STREAM;
                    idx_next     = '0;
                    rd_data_next = buf_rd[0];
                end else begin
                    row_next   = row_reg + 3'd1;
                    state_next = S_APPLY;
                end
            end
            S_STREAM: begin
                if (tt.rd_ready) begin
                    if (idx_reg == 3'd7) begin
                        state_next   = S_DONE;
                        idx_next     = '0;
                        rd_data_next = '0;
                    end else begin
                        // Preload the next row so a held rd_ready gives
                        // back-to-back transfers.
                        idx_next     = idx_reg + 3'd1;
                        rd_data_next = buf_rd[idx_reg + 3'd1];
                    end
                end
            end
            S_DONE: begin
                // One cycle outside IDLE so a start coinciding with done is ignored.
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // The block sees the row only while it is being applied or sampled.
        in_next = (state_next == S_APPLY || state_next == S_SAMPLE) ? row_next : 3'd0;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg        <= '0;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            in_reg         <= '0;
            rd_data_reg    <= '0;
            out_sample_reg <= '0;
        end else begin
            row_reg        <= row_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            in_reg         <= in_next;
            rd_data_reg    <= rd_data_next;
            // The block outputs are registered on entry; the value written in
            // SAMPLE is therefore what the block showed in the last APPLY cycle,
            // i.e. after the combination had been held exactly SETTLE_CYCLES.
            out_sample_reg <= {tt.out1, tt.out2, tt.out3, tt.out4};
        end
    end

    // Capture buffer, one register per row
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_buf
            logic [3:0] entry_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (buf_we && row_reg == 3'(gi)) begin
                    entry_reg <= out_sample_reg;
                end
            end
            assign buf_rd[gi] = entry_reg;
        end
    endgenerate

`ifdef TT_CHECK_EN
    logic [7:0] mask_reg;
    logic [3:0] expect_nib;

    assign expect_nib = EXPECTED_TT[{row_reg, 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_reg <= '0;
        end else if (state_reg == S_IDLE && tt.start) begin
            mask_reg <= '0;
        end else if (buf_we) begin
            mask_reg[row_reg] <= (out_sample_reg != expect_nib);
        end
    end

    assign tt.mismatch_mask = mask_reg;
    assign tt.mismatch      = |mask_reg;
`endif

    assign {tt.in1, tt.in2, tt.in3} = in_reg;
    assign tt.busy     = (state_reg == S_APPLY) || (state_reg == S_SAMPLE) ||
                         (state_reg == S_STREAM);
    assign tt.done     = (state_reg == S_DONE);
    assign tt.rd_valid = (state_reg == S_STREAM);
    assign tt.rd_row   = idx_reg;
    assign tt.rd_data  = rd_data_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
`timescale 1ns/1ps
module tb_truth_table_sweeper;
    localparam int          S       = 4;
    localparam logic [31:0] GOLD_TT = 32'h6C9C6090;

    logic clk = 1'b0;
    logic rst = 1'b1;

    truth_table_sweeper_if ifc();

    truth_table_sweeper #(
        .SETTLE_CYCLES(S),
        .CNT_W        (8),
        .EXPECTED_TT  (GOLD_TT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tt (ifc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Logic block model configuration
    int delay  = 0;   // cycles from an input change to the output change
    bit stuck4 = 1'b0;
    logic [2:0] hist [8];

    // Sweep-level reference model
    int cyc     = 0;
    int m_phase = 0;  // 0 idle, 1 sweeping, 2 streaming, 3 done cycle
    int m_k     = 0;  // cycle index since the first applied combination
    int m_idx   = 0;  // row the consumer should see next
    logic [3:0] got [8];
    int start_cyc = 0, first_valid_cyc = 0, done_cyc = 0;
    bit prev_valid = 1'b0;

    logic [3:0] gold_lit  [8] = '{4'h0, 4'h9, 4'h0, 4'h6, 4'hC, 4'h9, 4'hC, 4'h6};
    logic [3:0] stale_lit [8] = '{4'h0, 4'h0, 4'h9, 4'h0, 4'h6, 4'hC, 4'h9, 4'hC};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected captured value for row r: the block needs `delay` cycles to
    // follow a new combination, and a combination is held S cycles before it
    // is captured. If the block is too slow, the previous combination's
    // output is captured (combination 0 precedes row 0).
    function automatic logic [3:0] exp_row(input int r);
        logic [31:0] t;
        logic [3:0]  v;
        int          src;
        t   = GOLD_TT;
        src = (delay < S) ? r : ((r == 0) ? 0 : r - 1);
        v   = t[src*4 +: 4];
        if (stuck4) v[0] = 1'b0;
        return v;
    endfunction

    function automatic logic [7:0] model_mask();
        logic [31:0] t;
        logic [7:0]  m;
        t = GOLD_TT;
        m = '0;
        for (int r = 0; r < 8; r++) m[r] = (exp_row(r) != t[r*4 +: 4]);
        return m;
    endfunction

    // Logic block: output follows the input `delay` cycles later
    always @(posedge clk) begin
        for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= {ifc.in1, ifc.in2, ifc.in3};
    end

    always_comb begin : blk
        logic [2:0]  src;
        logic [3:0]  nib;
        logic [31:0] t;
        t   = GOLD_TT;
        src = (delay == 0) ? {ifc.in1, ifc.in2, ifc.in3} : hist[delay - 1];
        nib = t[{src, 2'b00} +: 4];
        if (stuck4) nib[0] = 1'b0;
        {ifc.out1, ifc.out2, ifc.out3, ifc.out4} = nib;
    end

    // Reference model update
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_k     = 0;
            m_idx   = 0;
        end else begin
            cyc++;
            case (m_phase)
                0: if (ifc.start) begin
                    m_phase = 1;
                    m_k     = 0;
                end
                1: begin
                    m_k++;
                    if (m_k == 8 * (S + 1)) begin
                        m_phase = 2;
                        m_idx   = 0;
                    end
                end
                2: if (ifc.rd_ready) begin
                    got[m_idx] = ifc.rd_data;
                    $display("xfer row %0d data 0x%h cycle %0d", ifc.rd_row, ifc.rd_data, cyc);
                    if (m_idx == 7) m_phase = 3;
                    else            m_idx++;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin : cmp
        int exp_in;
        exp_in = (m_phase == 1) ? m_k / (S + 1) : 0;
        chk("busy",     32'(ifc.busy),     32'(m_phase == 1 || m_phase == 2));
        chk("done",     32'(ifc.done),     32'(m_phase == 3));
        chk("rd_valid", 32'(ifc.rd_valid), 32'(m_phase == 2));
        chk("in",       32'({ifc.in1, ifc.in2, ifc.in3}), 32'(exp_in));
        if (m_phase == 2) begin
            chk("rd_row",  32'(ifc.rd_row),  32'(m_idx));
            chk("rd_data", 32'(ifc.rd_data), 32'(exp_row(m_idx)));
        end
`ifdef TT_CHECK_EN
        if (m_phase == 1 && m_k == 0) chk("mask_clear", 32'(ifc.mismatch_mask), 32'h0);
        if (m_phase == 3) begin
            chk("mask",     32'(ifc.mismatch_mask), 32'(model_mask()));
            chk("mismatch", 32'(ifc.mismatch),      32'(|model_mask()));
        end
`endif
        if (ifc.rd_valid && !prev_valid) first_valid_cyc = cyc;
        if (ifc.done) done_cyc = cyc;
        prev_valid = ifc.rd_valid;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},     32'(ifc.busy),     32'h0);
        chk({tag, "_done"},     32'(ifc.done),     32'h0);
        chk({tag, "_rd_valid"}, 32'(ifc.rd_valid), 32'h0);
        chk({tag, "_rd_row"},   32'(ifc.rd_row),   32'h0);
        chk({tag, "_rd_data"},  32'(ifc.rd_data),  32'h0);
        chk({tag, "_in"},       32'({ifc.in1, ifc.in2, ifc.in3}), 32'h0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #2;
        ifc.start = 1'b1;
        @(posedge clk); #2;
        start_cyc = cyc;
        ifc.start = 1'b0;
    endtask

    // One full sweep; rnd toggles rd_ready randomly, poke issues ignored
    // start pulses at sweep cycle 10 and on the done cycle.
    task automatic run_sweep(input int d, input bit rnd, input bit poke, input bit stuck);
        int n;
        bit fin;
        delay  = d;
        stuck4 = stuck;
        pulse_start();
        n   = 0;
        fin = 1'b0;
        while (!fin && n < 3000) begin
            ifc.rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && n == 10) ifc.start = 1'b1;
            @(posedge clk); #2;
            ifc.start = 1'b0;
            n++;
            if (ifc.done) begin
                fin = 1'b1;
                if (poke) ifc.start = 1'b1;
                @(posedge clk); #2;
                ifc.start = 1'b0;
            end
        end
        chk("sweep_finished", 32'(fin), 32'h1);
        ifc.rd_ready = 1'b1;
        @(posedge clk); #2;
    endtask

    initial begin
        int n;
        ifc.start    = 1'b0;
        ifc.rd_ready = 1'b1;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("por");
        rst = 1'b0;

        // Golden sweep, consumer always ready
        run_sweep(0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) chk($sformatf("gold_row%0d", r), 32'(got[r]), 32'(gold_lit[r]));
        chk("sweep_latency", 32'(first_valid_cyc - start_cyc), 32'd40);
        chk("stream_len",    32'(done_cyc - first_valid_cyc),  32'd8);

        // Backpressure plus start pulses while busy / on done
        repeat (3) run_sweep(0, 1'b1, 1'b1, 1'b0);

        // Settle timing
        run_sweep(3, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) chk($sformatf("settle3_row%0d", r), 32'(got[r]), 32'(gold_lit[r]));
        run_sweep(4, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) chk($sformatf("settle4_row%0d", r), 32'(got[r]), 32'(stale_lit[r]));

        // Asynchronous reset while row 3 is applied
        delay  = 0;
        stuck4 = 1'b0;
        pulse_start();
        n = 0;
        while ({ifc.in1, ifc.in2, ifc.in3} != 3'd3 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("reach_row3", 32'({ifc.in1, ifc.in2, ifc.in3}), 32'd3);
        #1 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(posedge clk); #2;
        rst = 1'b0;
        run_sweep(0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) chk($sformatf("post_rst_row%0d", r), 32'(got[r]), 32'(gold_lit[r]));

`ifdef TT_CHECK_EN
        // out4 stuck at 0 breaks rows 1 and 5
        run_sweep(0, 1'b0, 1'b0, 1'b1);
        chk("stuck_mask",     32'(ifc.mismatch_mask), 32'h22);
        chk("stuck_mismatch", 32'(ifc.mismatch),      32'h1);
        run_sweep(0, 1'b0, 1'b0, 1'b0);
        chk("clean_mask",     32'(ifc.mismatch_mask), 32'h0);
        chk("clean_mismatch", 32'(ifc.mismatch),      32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
